// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared main-memory port to one of three requesters
// (D-side store, D-cache fill, I-cache fill), issues eight pipelined word
// reads per fill and steers the returned words into the owning cache.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no grant held; arbitration evaluated here only
// FILL_I | I-cache block fill: issuing reads and/or collecting words
// FILL_D | D-cache block fill: issuing reads and/or collecting words
// WRITE  | single-cycle write-through store on the memory port
module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int WORDS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    input  logic        d_wr,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        fill_we_i,
    output logic        fill_we_d,
    output logic        i_done,
    output logic        d_done,
    output logic        wr_done,
    output logic        i_busy,
    output logic        d_busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILL_I = 2'd1;
    localparam logic [1:0] FILL_D = 2'd2;
    localparam logic [1:0] WRITE  = 2'd3;

    localparam logic [2:0] LAST_WORD = 3'(WORDS - 1);
    localparam logic [3:0] FLUSH_INIT = 4'(MEM_LAT);

    logic [1:0]  state;
    logic [2:0]  ic;
    logic [2:0]  rc;
    logic        issuing;
    logic [11:0] blk;
    logic        last_fill_d;
    logic [3:0]  flush_cnt;

    logic        wr_req;
    logic        dm_req;
    logic        im_req;
    logic        grant_i;
    logic        in_fill;
    logic        rv_ok;
    logic        unused_bits;

    // Low nibble of miss addresses selects a byte within the block; unused.
    assign unused_bits = ^{i_miss_addr[3:0], d_miss_addr[3:0]};

    // Requests whose done pulse is showing this cycle are already served.
    assign wr_req  = d_wr & ~wr_done;
    assign dm_req  = d_miss & ~d_done;
    assign im_req  = i_miss & ~i_done;
    // I wins over D when D filled last (anti-starvation) or D is not asking.
    assign grant_i = im_req & (last_fill_d | ~dm_req);

    assign in_fill = (state == FILL_I) | (state == FILL_D);
    // Read data still in flight from before a reset is dropped until the
    // memory pipeline has had MEM_LAT cycles to drain.
    assign rv_ok   = mem_rvalid & (flush_cnt == 4'd0);

    // Sequencer: grant, issue/receive counters, done pulses, fairness memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ic          <= 3'd0;
            rc          <= 3'd0;
            issuing     <= 1'b0;
            blk         <= 12'd0;
            last_fill_d <= 1'b0;
            flush_cnt   <= FLUSH_INIT;
            i_done      <= 1'b0;
            d_done      <= 1'b0;
            wr_done     <= 1'b0;
        end else begin
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            wr_done <= 1'b0;
            if (flush_cnt != 4'd0) begin
                flush_cnt <= flush_cnt - 4'd1;
            end
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        state <= WRITE;
                    end else if (grant_i) begin
                        state   <= FILL_I;
                        blk     <= i_miss_addr[15:4];
                        issuing <= 1'b1;
                        ic      <= 3'd0;
                        rc      <= 3'd0;
                    end else if (dm_req) begin
                        state   <= FILL_D;
                        blk     <= d_miss_addr[15:4];
                        issuing <= 1'b1;
                        ic      <= 3'd0;
                        rc      <= 3'd0;
                    end
                end
                FILL_I, FILL_D: begin
                    if (issuing) begin
                        ic <= ic + 3'd1;
                        if (ic == LAST_WORD) begin
                            issuing <= 1'b0;
                        end
                    end
                    if (rv_ok) begin
                        rc <= rc + 3'd1;
                        if (rc == LAST_WORD) begin
                            state <= IDLE;
                            if (state == FILL_I) begin
                                i_done      <= 1'b1;
                                last_fill_d <= 1'b0;
                            end else begin
                                d_done      <= 1'b1;
                                last_fill_d <= 1'b1;
                            end
                        end
                    end
                end
                WRITE: begin
                    state   <= IDLE;
                    wr_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory port drive: reads while issuing a fill, one write in WRITE.
    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 16'd0;
        mem_wdata = 16'd0;
        if (state == WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = d_wr_addr;
            mem_wdata = d_wr_data;
        end else if (in_fill && issuing) begin
            mem_en   = 1'b1;
            mem_addr = {blk, ic, 1'b0};
        end
    end

    // Fill steering: returned words go to whichever cache owns the grant.
    always_comb begin
        fill_data = mem_rdata;
        fill_word = rc;
        fill_we_i = (state == FILL_I) & rv_ok;
        fill_we_d = (state == FILL_D) & rv_ok;
    end

    // Stall sources, deliberately unregistered.
    always_comb begin
        i_busy = i_miss & ~i_done;
        d_busy = (d_miss | d_wr) & ~(d_done | wr_done);
    end

endmodule
